pipelined_ripple_adder: RTL
===========================

// Module: pipelined_ripple_adder
// PURPOSE
//  Parametrised, pipelined successor to the combinational ripple adder. Splits a
//  WIDTH-bit add/subtract into STAGES ripple segments, registering the carry
//  between segments so the critical path is WIDTH/STAGES full adders. Sits in the
//  Radix-4 multiplier datapath (partial-product reduction and final sum) behind a
//  valid/ready handshake, with one result per cycle at full throughput.
// PARAMETERS
//  WIDTH   16  operand width in bits; must be a multiple of STAGES
//  STAGES   4  pipeline segments = latency in cycles; 1 <= STAGES <= WIDTH
// PORTS
//  i_clk      in   1        clock, rising edge
//  i_rst_n    in   1        asynchronous reset, active-low
//  i_valid    in   1        input operands valid
//  o_ready    out  1        block accepts input this cycle
//  i_sub      in   1        0: A+B ; 1: A-B (A + ~B + 1)
//  i_add1     in   WIDTH    operand A
//  i_add2     in   WIDTH    operand B
//  o_valid    out  1        o_result valid
//  i_ready    in   1        downstream accepts result
//  o_result   out  WIDTH+1  {carry_out, sum}; for sub, MSB=1 means no borrow
//  o_overflow out  1        signed (two's complement) overflow of the WIDTH-bit sum
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the system): all stage valid bits 0,
//    all data/carry registers 0; o_valid=0, o_result=0, o_overflow=0, o_ready=1.
//  - SEG = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*SEG +: SEG] of A and
//    B' (B' = i_sub ? ~B : B) with carry-in = registered carry of stage k-1
//    (stage 0: carry-in = i_sub). Upper unsummed segments and i_sub travel with
//    the data; lower finished sum segments are carried forward unchanged.
//  - Latency exactly STAGES cycles from accepted input to o_valid, no bubbles.
//  - Advance: adv = !o_valid | i_ready. o_ready = adv (combinational).
//    Input accepted when i_valid & o_ready. When adv=1 every stage shifts one
//    place; when adv=0 every stage register (data and valid) holds.
//  - o_valid, o_result, o_overflow are registered, stable while o_valid & !i_ready.
//  - Bubbles: an empty stage (valid=0) shifts as empty; data in empty stages is
//    don't-care but must not produce o_valid.
//  - Simultaneous accept at input and consume at output: both occur, throughput 1/cycle.
//  - o_overflow = carry into MSB XOR carry out of MSB (computed in last stage).
//  - STAGES=1: single registered ripple adder, latency 1.
//  - Reset asserted mid-operation: all in-flight results discarded, no o_valid
//    after release until a new input traverses STAGES cycles.
//  - Illegal parameters (WIDTH % STAGES != 0): elaboration-time $error.
// STRUCTURE
//  - Shared include adder_defs.vh: default WIDTH/STAGES, SEG derivation macro.
//  - One sub-module: ripple_segment #(SEG) with i_carry input, built from
//    full_adder instances (i_add1, i_add2, i_carry -> o_sum[SEG-1:0], o_carry).
//  - Top: generate loop of STAGES ripple_segment instances, per-stage pipeline
//    registers (valid, sub, carry, A/B remainder, partial sum), global adv enable.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//  1. Reset release, A=0x1234,B=0x1111,add, i_ready=1 -> o_valid exactly 4 cycles
//     after accept, o_result=0x02345, o_overflow=0.
//  2. Carry across all segments: A=0xFFFF,B=0x0001 -> o_result=0x10000; A=0x7FFF,
//     B=0x0001 -> 0x08000, o_overflow=1.
//  3. Subtract: A=0x0005,B=0x0007,sub -> o_result=0x0FFFE (no-borrow bit 0);
//     A=0x8000,B=0x0001 -> 0x17FFF, o_overflow=1.
//  4. Back-to-back 20 random inputs, i_ready held 0 for 3 cycles mid-stream ->
//     o_ready=0 while o_valid&!i_ready, results in order, none lost/duplicated,
//     held values stable.
//  5. Reset pulsed with 3 results in flight -> o_valid=0 immediately, no stale
//     output afterwards; next input emerges after 4 cycles.
//  6. STAGES=1 and STAGES=16 builds, 1000 random add/sub vs reference model ->
//     bit-exact o_result/o_overflow, latency 1 and 16 respectively.

Source files
------------

// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared defaults and parameter helpers for the pipelined ripple adder.
package pipelined_ripple_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_STAGES = 4;

  // Bits summed per pipeline stage; guards against a zero stage count.
  function automatic int unsigned seg_width(input int unsigned width,
                                            input int unsigned stages);
    return (stages == 0) ? width : width / stages;
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
module full_adder (
  input  logic i_add1,
  input  logic i_add2,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_add1 ^ i_add2 ^ i_carry;
  assign o_carry = (i_add1 & i_add2) | (i_carry & (i_add1 ^ i_add2));

endmodule

// File: rtl/ripple_segment.sv
// SEG-bit combinational ripple-carry segment built from full adders.
module ripple_segment #(
  parameter int unsigned SEG = 4
) (
  input  logic [SEG-1:0] i_add1,
  input  logic [SEG-1:0] i_add2,
  input  logic           i_carry,
  output logic [SEG-1:0] o_sum,
  output logic           o_carry
);

  logic [SEG:0] carry_c;

  assign carry_c[0] = i_carry;
  assign o_carry    = carry_c[SEG];

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .i_add1  (i_add1[i]),
      .i_add2  (i_add2[i]),
      .i_carry (carry_c[i]),
      .o_sum   (o_sum[i]),
      .o_carry (carry_c[i+1])
    );
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined add/subtract: STAGES ripple segments with registered carries and a
// valid/ready handshake; one result per cycle, latency STAGES.
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_overflow
);

  localparam int unsigned SEG = seg_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  // Whole pipeline moves together unless a valid result is stuck at the output.
  logic adv_c;
  logic ovf_q;

  assign adv_c      = !o_valid || i_ready;
  assign o_ready    = adv_c;
  assign o_overflow = ovf_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO  = k * SEG;      // bits already summed before this stage
    localparam int unsigned REM = WIDTH - LO;   // operand bits still to be summed

    logic [REM-1:0]    a_c;
    logic [REM-1:0]    b_c;
    logic              cin_c;
    logic              vld_c;
    logic [SEG-1:0]    seg_sum_c;
    logic              seg_cout_c;
    logic [LO+SEG-1:0] sum_next_c;
    logic [LO+SEG-1:0] sum_q;
    logic              carry_q;
    logic              vld_q;

    if (k == 0) begin : g_in
      assign a_c        = i_add1;
      assign b_c        = i_sub ? ~i_add2 : i_add2;
      assign cin_c      = i_sub;
      assign vld_c      = i_valid;
      assign sum_next_c = seg_sum_c;
    end else begin : g_link
      assign a_c        = g_stage[k-1].g_rem.a_q;
      assign b_c        = g_stage[k-1].g_rem.b_q;
      assign cin_c      = g_stage[k-1].carry_q;
      assign vld_c      = g_stage[k-1].vld_q;
      assign sum_next_c = {seg_sum_c, g_stage[k-1].sum_q};
    end

    ripple_segment #(.SEG(SEG)) u_seg (
      .i_add1  (a_c[SEG-1:0]),
      .i_add2  (b_c[SEG-1:0]),
      .i_carry (cin_c),
      .o_sum   (seg_sum_c),
      .o_carry (seg_cout_c)
    );

    // Stage valid, carry and finished low sum bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv_c) begin
        vld_q   <= vld_c;
        carry_q <= seg_cout_c;
        sum_q   <= sum_next_c;
      end
    end

    if (k < STAGES - 1) begin : g_rem
      logic [REM-SEG-1:0] a_q;
      logic [REM-SEG-1:0] b_q;

      // Unsummed upper operand bits (B already conditionally inverted).
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv_c) begin
          a_q <= a_c[REM-1:SEG];
          b_q <= b_c[REM-1:SEG];
        end
      end
    end else begin : g_last
      logic ovf_c;

      // Carry into the MSB equals a^b^sum at the MSB; XOR with carry out.
      assign ovf_c = a_c[REM-1] ^ b_c[REM-1] ^ seg_sum_c[SEG-1] ^ seg_cout_c;

      // Registered signed overflow of the final result.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv_c) begin
          ovf_q <= ovf_c;
        end
      end
    end
  end

  assign o_valid  = g_stage[STAGES-1].vld_q;
  assign o_result = {g_stage[STAGES-1].carry_q, g_stage[STAGES-1].sum_q};

endmodule
